// File: rtl/btn_ctrl_pkg.sv
// Shared types and BCD helper for the button-driven two-digit counter.
package btn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    REPEAT   = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  typedef enum logic {
    OWN_UP = 1'b0,
    OWN_DN = 1'b1
  } owner_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // One BCD step in the given direction; returns {tens, ones}, wrapping 99<->00.
  function automatic logic [7:0] bcd_step(input logic [3:0] tens,
                                          input logic [3:0] ones,
                                          input owner_t     dir);
    logic [3:0] t;
    logic [3:0] o;
    t = tens;
    o = ones;
    if (dir == OWN_UP) begin
      if (ones == BCD_MAX) begin
        o = BCD_ZERO;
        t = (tens == BCD_MAX) ? BCD_ZERO : tens + 4'd1;
      end else begin
        o = ones + 4'd1;
      end
    end else begin
      if (ones == BCD_ZERO) begin
        o = BCD_MAX;
        t = (tens == BCD_ZERO) ? BCD_MAX : tens - 4'd1;
      end else begin
        o = ones - 4'd1;
      end
    end
    return {t, o};
  endfunction

endpackage

// File: rtl/button_counter_ctrl_debounce.sv
// Two-flop synchronizer followed by a saturating stable-high counter.
// db is high only once the synchronized input has been 1 for DEB_CYCLES cycles.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic db
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep this a true two-stage shift; blocking would collapse it to one flop.
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  // Count stable-high cycles, saturate at the threshold, drop to zero on any low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!sync_2) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign db = (cnt == CNT_MAX);

endmodule

// File: rtl/button_counter_ctrl.sv
// Two-button BCD up/down counter controller with debounce and arbitration.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat stepping (REPEAT_DELAY/REPEAT_RATE).
module button_counter_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES   = 250000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_dn,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       step_pulse,
  output logic       busy
);

  logic   db_up;
  logic   db_dn;
  logic   db_up_q;
  logic   db_dn_q;
  logic   up_press;
  logic   dn_press;
  logic   owner_db;
  state_t state;
  owner_t owner;

`ifdef AUTO_REPEAT_EN
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW      = $clog2(TMR_MAX + 1);
  logic [TW-1:0] timer;
`endif

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_up),
    .db      (db_up)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_dn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_dn),
    .db      (db_dn)
  );

  // A press is a fresh rise of the debounced level, so a button still held
  // after the other one releases cannot start a new step.
  assign up_press = db_up & ~db_up_q;
  assign dn_press = db_dn & ~db_dn_q;
  assign owner_db = (owner == OWN_UP) ? db_up : db_dn;
  assign busy     = (state != IDLE);

  // FSM, arbitration, optional repeat timer and the BCD digit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_UP;
      ones       <= BCD_ZERO;
      tens       <= BCD_ZERO;
      step_pulse <= 1'b0;
      db_up_q    <= 1'b0;
      db_dn_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      timer      <= '0;
`endif
    end else begin
      step_pulse <= 1'b0;
      db_up_q    <= db_up;
      db_dn_q    <= db_dn;
      case (state)
        IDLE: begin
          if (up_press || dn_press) begin
            step_pulse <= 1'b1;
            if (db_up && db_dn) begin
              {tens, ones} <= {BCD_ZERO, BCD_ZERO};
              state        <= WAIT_REL;
            end else if (up_press) begin
              {tens, ones} <= bcd_step(tens, ones, OWN_UP);
              owner        <= OWN_UP;
              state        <= HELD;
            end else begin
              {tens, ones} <= bcd_step(tens, ones, OWN_DN);
              owner        <= OWN_DN;
              state        <= HELD;
            end
          end
        end
        HELD: begin
          if (!owner_db) begin
            state <= IDLE;
`ifdef AUTO_REPEAT_EN
            timer <= '0;
          end else if (timer == TW'(REPEAT_DELAY - 1)) begin
            {tens, ones} <= bcd_step(tens, ones, owner);
            step_pulse   <= 1'b1;
            state        <= REPEAT;
            timer        <= '0;
          end else begin
            timer <= timer + TW'(1);
`endif
          end
        end
`ifdef AUTO_REPEAT_EN
        REPEAT: begin
          if (!owner_db) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == TW'(REPEAT_RATE - 1)) begin
            {tens, ones} <= bcd_step(tens, ones, owner);
            step_pulse   <= 1'b1;
            timer        <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
`endif
        WAIT_REL: begin
          if (!db_up && !db_dn) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_counter_ctrl.sv
// Scoreboard bench for button_counter_ctrl: each press pushes the expected
// value and pulse cycle; a negedge monitor pops on every step_pulse.
module tb_button_counter_ctrl;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up;
  logic       btn_dn;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       step_pulse;
  logic       busy;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   v      = 0;
  exp_t q[$];

  button_counter_ctrl #(
    .DEB_CYCLES   (4)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (5)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (btn_up),
    .btn_dn     (btn_dn),
    .ones       (ones),
    .tens       (tens),
    .step_pulse (step_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] enc(input int val);
    return {4'(val / 10), 4'(val % 10)};
  endfunction

  // Ends 1 time unit after a rising edge, the point where inputs are driven.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_step(input logic [7:0] val, input int at);
    exp_t e;
    e.val = val;
    e.cyc = at;
    q.push_back(e);
  endtask

  // Clean press of one button; first step lands 7 edges after the raw rise.
  task automatic press(input bit up, input int hold);
    if (up) btn_up = 1'b1; else btn_dn = 1'b1;
    v = up ? (v + 1) % 100 : (v + 99) % 100;
    expect_step(enc(v), cyc + 7);
    wait_cyc(hold);
    if (up) btn_up = 1'b0; else btn_dn = 1'b0;
    wait_cyc(6);
  endtask

  task automatic check_value(input string tag);
    check(tag, {24'b0, tens, ones}, {24'b0, enc(v)});
    check({tag, "_drained"}, q.size(), 0);
  endtask

  // Scoreboard monitor, sampling opposite the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && step_pulse) begin
      if (q.size() == 0) begin
        check("spurious_pulse", {31'b0, step_pulse}, 0);
      end else begin
        e = q.pop_front();
        check("pulse_value", {24'b0, tens, ones}, {24'b0, e.val});
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int n;
    int k;
    int c;
    bit lvl;
    rst_n  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
    check("rst_ones", {28'b0, ones}, 0);
    check("rst_tens", {28'b0, tens}, 0);
    check("rst_busy", {31'b0, busy}, 0);

    // Reset asserted in the middle of a debounce count.
    press(1'b1, 10);
    check_value("pre_reset");
    btn_up = 1'b1;
    wait_cyc(3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ones", {28'b0, ones}, 0);
    check("rst_mid_tens", {28'b0, tens}, 0);
    check("rst_mid_busy", {31'b0, busy}, 0);
    check("rst_mid_pulse", {31'b0, step_pulse}, 0);
    btn_up = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    v = 0;
    wait_cyc(10);
    check_value("post_reset");
    check("post_reset_busy", {31'b0, busy}, 0);

    // Bounce: high and low runs of 1-2 cycles never satisfy the debouncer.
    n   = 0;
    lvl = 1'b0;
    while (n < 30) begin
      lvl    = ~lvl;
      btn_up = lvl;
      k      = $urandom_range(1, 2);
      wait_cyc(k);
      n += k;
    end
    btn_up = 1'b0;
    wait_cyc(2);
    press(1'b1, 10);
    check_value("bounce");

    // Wrap and borrow.
    press(1'b0, 10);
    press(1'b0, 10);
    check_value("wrap_down_99");
    press(1'b1, 10);
    check_value("wrap_up_00");
    for (int i = 0; i < 10; i++) press(1'b1, 8);
    check_value("reach_10");
    press(1'b0, 10);
    check_value("borrow_09");

    // Arbitration: UP owns the counter, DN is ignored, UP release does not hand over.
    btn_up = 1'b1;
    v = (v + 1) % 100;
    expect_step(enc(v), cyc + 7);
    wait_cyc(10);
    btn_dn = 1'b1;
    wait_cyc(10);
    check("arb_busy_held", {31'b0, busy}, 1);
    btn_up = 1'b0;
    wait_cyc(12);
    check("arb_busy_idle", {31'b0, busy}, 0);
    check_value("arb_no_clear");
    btn_dn = 1'b0;
    wait_cyc(6);
    check_value("arb_dn_release");
    press(1'b0, 10);
    check_value("arb_dn_repress");

    // Clear from 37 with both buttons rising together.
    for (int i = 0; i < 28; i++) press(1'b1, 8);
    check_value("reach_37");
    btn_up = 1'b1;
    btn_dn = 1'b1;
    v = 0;
    expect_step(enc(v), cyc + 7);
    wait_cyc(12);
    check("clr_busy", {31'b0, busy}, 1);
    btn_up = 1'b0;
    wait_cyc(8);
    check("clr_busy_one_held", {31'b0, busy}, 1);
    check_value("clear_00");
    btn_dn = 1'b0;
    wait_cyc(6);
    check("clr_busy_released", {31'b0, busy}, 0);

    // Long hold from 05.
    for (int i = 0; i < 5; i++) press(1'b1, 8);
    check_value("reach_05");
    c = cyc;
    btn_up = 1'b1;
    v = 6;
    expect_step(enc(6), c + 7);
`ifdef AUTO_REPEAT_EN
    expect_step(enc(7),  c + 27);
    expect_step(enc(8),  c + 32);
    expect_step(enc(9),  c + 37);
    expect_step(enc(10), c + 42);
    v = 10;
`endif
    wait_cyc(40);
    btn_up = 1'b0;
    wait_cyc(12);
    check_value("hold");
    check("hold_busy_released", {31'b0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
